// File: rtl/tc_fetch_pkg.sv
// Shared types and default sizes for the tc_program_fetch8 instruction fetch front-end.
package tc_fetch_pkg;

    localparam int unsigned DefInstrBytes = 4;
    localparam int unsigned DefAddrW      = 16;

    typedef enum logic [0:0] {
        FETCH,
        STALL
    } fetch_state_t;

endpackage

// File: rtl/tc_fetch_assembler.sv
// Byte assembler: captured ROM bytes fill slots 0..INSTR_BYTES-2. The final byte bypasses
// the slots, so the finished word is visible in the same cycle that byte arrives.
module tc_fetch_assembler #(
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     capture_i,
    input  logic                     clear_i,
    input  logic [7:0]               data_i,
    output logic                     at_last_o,
    output logic                     complete_o,
    output logic [8*INSTR_BYTES-1:0] word_o
);

    localparam int unsigned     CntW    = $clog2(INSTR_BYTES);
    localparam int unsigned     SlotW   = 8 * (INSTR_BYTES - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(INSTR_BYTES - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [SlotW-1:0] slot_q, slot_d;

    assign at_last_o  = (cnt_q == LastCnt);
    assign complete_o = capture_i && !clear_i && at_last_o;
    assign word_o     = {data_i, slot_q};

    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (capture_i) begin
            if (at_last_o) begin
                cnt_d = '0;
            end else begin
                for (int unsigned k = 0; k < INSTR_BYTES - 1; k++) begin
                    if (cnt_q == CntW'(k)) begin
                        slot_d[8*k +: 8] = data_i;
                    end
                end
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            slot_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/tc_program_fetch8.sv
// Instruction fetch front-end for an 8-bit registered-read program ROM, with jump redirect and
// stall/replay. Define PROGRAM_FETCH_ALIGN_CHECK_EN to round jump targets down and add align_err.
module tc_program_fetch8
    import tc_fetch_pkg::*;
#(
    parameter int unsigned INSTR_BYTES = DefInstrBytes,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [7:0]               mem_data,
    input  logic                     jump_valid,
    input  logic [ADDR_W-1:0]        jump_target,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [8*INSTR_BYTES-1:0] instr_data,
    output logic [ADDR_W-1:0]        instr_pc
`ifdef PROGRAM_FETCH_ALIGN_CHECK_EN
    ,
    output logic                     align_err
`endif
);

    fetch_state_t             state_q, state_d;
    logic [ADDR_W-1:0]        fp_q, fp_d;
    logic [ADDR_W-1:0]        raddr_q, raddr_d;
    logic                     rvalid_q, rvalid_d;
    logic                     valid_q, valid_d;
    logic [8*INSTR_BYTES-1:0] data_q, data_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]        target_eff;
    logic                     drain, slot_free, blocked, capture, at_last, complete;
    logic [8*INSTR_BYTES-1:0] word;

`ifdef PROGRAM_FETCH_ALIGN_CHECK_EN
    logic [ADDR_W-1:0] target_ofs;
    logic              align_err_q, align_err_d;

    assign target_ofs  = jump_target % ADDR_W'(INSTR_BYTES);
    assign target_eff  = jump_target - target_ofs;
    assign align_err_d = jump_valid && (target_ofs != '0);
    assign align_err   = align_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`else
    assign target_eff = jump_target;
`endif

    assign drain     = valid_q && instr_ready;
    assign slot_free = !valid_q || drain;
    // Last byte of a word arriving while the slot cannot take the word: drop it and replay later.
    assign blocked   = rvalid_q && at_last && !slot_free;
    assign capture   = rvalid_q && !jump_valid && !blocked;

    tc_fetch_assembler #(
        .INSTR_BYTES(INSTR_BYTES)
    ) u_assembler (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .capture_i (capture),
        .clear_i   (jump_valid),
        .data_i    (mem_data),
        .at_last_o (at_last),
        .complete_o(complete),
        .word_o    (word)
    );

    always_comb begin
        state_d  = state_q;
        fp_d     = fp_q;
        raddr_d  = fp_q;
        rvalid_d = 1'b0;
        valid_d  = valid_q && !drain;
        data_d   = data_q;
        pc_d     = pc_q;

        if (complete) begin
            valid_d = 1'b1;
            data_d  = word;
            pc_d    = raddr_q - ADDR_W'(INSTR_BYTES - 1);
        end

        case (state_q)
            FETCH: begin
                if (blocked) begin
                    fp_d    = raddr_q;
                    state_d = STALL;
                end else begin
                    fp_d     = fp_q + ADDR_W'(1);
                    rvalid_d = 1'b1;
                end
            end
            STALL: begin
                if (slot_free) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (jump_valid) begin
            fp_d     = target_eff;
            rvalid_d = 1'b0;
            valid_d  = 1'b0;
            state_d  = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            fp_q     <= ADDR_W'(RESET_PC);
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            fp_q     <= fp_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            pc_q     <= pc_d;
        end
    end

    assign mem_addr    = fp_q;
    assign instr_valid = valid_q;
    assign instr_data  = data_q;
    assign instr_pc    = pc_q;

endmodule

// File: tb/tb_tc_program_fetch8.sv
// Self-checking bench for tc_program_fetch8: directed scenarios plus a randomized run against
// a word-stream model (expected PC advances by INSTR_BYTES per accepted word, reset by jumps).
module tb_tc_program_fetch8;

    localparam int          IB     = 4;
    localparam int          AW     = 16;
    localparam int unsigned RST_PC = 0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_data;
    logic            jump_valid = 1'b0;
    logic [AW-1:0]   jump_target = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [8*IB-1:0] instr_data;
    logic [AW-1:0]   instr_pc;
`ifdef PROGRAM_FETCH_ALIGN_CHECK_EN
    logic            align_err;
`endif

    logic [7:0] rom [65536];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic            s_valid, s_hs, s_align;
    logic [AW-1:0]   s_pc, s_addr;
    logic [8*IB-1:0] s_data;

    tc_program_fetch8 #(
        .INSTR_BYTES(IB),
        .ADDR_W     (AW),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .jump_valid (jump_valid),
        .jump_target(jump_target),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data (instr_data),
        .instr_pc   (instr_pc)
`ifdef PROGRAM_FETCH_ALIGN_CHECK_EN
        ,
        .align_err  (align_err)
`endif
    );

    always #5 clk = ~clk;

    // Registered-read ROM: output is zero straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_data <= 8'h00;
        else        mem_data <= rom[mem_addr];
    end

    function automatic logic [8*IB-1:0] model_word(input logic [AW-1:0] pc);
        logic [8*IB-1:0] w;
        logic [AW-1:0]   a;
        for (int k = 0; k < IB; k++) begin
            a = pc + AW'(k);
            w[8*k +: 8] = rom[a];
        end
        return w;
    endfunction

    function automatic logic [AW-1:0] model_target(input logic [AW-1:0] t);
`ifdef PROGRAM_FETCH_ALIGN_CHECK_EN
        int unsigned v;
        v = (int'(t) / IB) * IB;
        return AW'(v);
`else
        return t;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        s_valid = instr_valid;
        s_hs    = instr_valid && instr_ready;
        s_pc    = instr_pc;
        s_data  = instr_data;
        s_addr  = mem_addr;
`ifdef PROGRAM_FETCH_ALIGN_CHECK_EN
        s_align = align_err;
`else
        s_align = 1'b0;
`endif
        @(posedge clk);
        #1;
        jump_valid = 1'b0;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        jump_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== AW'(RST_PC)) begin
            n_fail++; $display("FAIL reset_mem_addr got %h want %h", mem_addr, AW'(RST_PC));
        end
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid);
        end
        n_checks++;
        if (instr_data !== '0 || instr_pc !== '0) begin
            n_fail++; $display("FAIL reset_out got data %h pc %h want 0 0", instr_data, instr_pc);
        end
    endtask

    task automatic test_stream();
        logic          exp_v;
        logic [AW-1:0] exp_pc;
        apply_reset();
        instr_ready = 1'b1;
        exp_pc      = AW'(RST_PC);
        for (int c = 0; c < 21; c++) begin
            tick();
            exp_v = (c >= IB + 1) && (((c - (IB + 1)) % IB) == 0);
            n_checks++;
            if (s_valid !== exp_v) begin
                n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, s_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (s_pc !== exp_pc || s_data !== model_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL stream_word c=%0d got %h/%h want %h/%h", c, s_pc, s_data,
                             exp_pc, model_word(exp_pc));
                end
                exp_pc = exp_pc + AW'(IB);
            end
        end
    endtask

    task automatic test_backpressure();
        logic          got;
        int            nh;
        logic [AW-1:0] exp_pc;
        apply_reset();
        instr_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = s_valid;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL bp_first_valid got none want valid within 20 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (s_valid !== 1'b1 || s_pc !== AW'(RST_PC) || s_data !== model_word(AW'(RST_PC))) begin
                n_fail++;
                $display("FAIL bp_hold i=%0d got %b %h %h want 1 %h %h", i, s_valid, s_pc,
                         s_data, AW'(RST_PC), model_word(AW'(RST_PC)));
            end
        end
        n_checks++;
        if (s_addr !== AW'(RST_PC + 2 * IB - 1)) begin
            n_fail++; $display("FAIL bp_stall_addr got %h want %h", s_addr, AW'(RST_PC + 2 * IB - 1));
        end
        instr_ready = 1'b1;
        exp_pc = AW'(RST_PC);
        nh = 0;
        for (int i = 0; i < 30 && nh < 3; i++) begin
            tick();
            if (s_hs) begin
                n_checks++;
                if (s_pc !== exp_pc || s_data !== model_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL bp_resume n=%0d got %h/%h want %h/%h", nh, s_pc, s_data,
                             exp_pc, model_word(exp_pc));
                end
                exp_pc = exp_pc + AW'(IB);
                nh++;
            end
        end
        n_checks++;
        if (nh != 3) begin
            n_fail++; $display("FAIL bp_resume_count got %0d want 3", nh);
        end
    endtask

    task automatic test_jump();
        logic          exp_v;
        logic [AW-1:0] exp_pc;
        int            t;
        apply_reset();
        instr_ready = 1'b1;
        repeat (3) tick();
        t           = 3;
        jump_valid  = 1'b1;
        jump_target = 16'h0040;
        exp_pc      = model_target(16'h0040);
        for (int c = t; c <= t + 2 * IB + 2; c++) begin
            tick();
            if (c == t + 1) begin
                n_checks++;
                if (s_addr !== exp_pc) begin
                    n_fail++; $display("FAIL jump_mem_addr got %h want %h", s_addr, exp_pc);
                end
            end
            exp_v = (c >= t + IB + 2) && (((c - (t + IB + 2)) % IB) == 0);
            n_checks++;
            if (s_valid !== exp_v) begin
                n_fail++; $display("FAIL jump_valid c=%0d got %b want %b", c, s_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (s_pc !== exp_pc || s_data !== model_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL jump_word c=%0d got %h/%h want %h/%h", c, s_pc, s_data,
                             exp_pc, model_word(exp_pc));
                end
                exp_pc = exp_pc + AW'(IB);
            end
        end
    endtask

    task automatic test_wrap();
        int            nh;
        logic [AW-1:0] exp_pc;
        apply_reset();
        instr_ready = 1'b1;
        repeat (2) tick();
        jump_valid  = 1'b1;
        jump_target = 16'hFFFE;
        exp_pc      = model_target(16'hFFFE);
        nh = 0;
        for (int i = 0; i < 30 && nh < 2; i++) begin
            tick();
            if (s_hs) begin
                n_checks++;
                if (s_pc !== exp_pc || s_data !== model_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL wrap_word n=%0d got %h/%h want %h/%h", nh, s_pc, s_data,
                             exp_pc, model_word(exp_pc));
                end
                exp_pc = exp_pc + AW'(IB);
                nh++;
            end
        end
        n_checks++;
        if (nh != 2) begin
            n_fail++; $display("FAIL wrap_count got %0d want 2", nh);
        end
    endtask

    task automatic test_reset_midword();
        logic exp_v;
        apply_reset();
        instr_ready = 1'b1;
        repeat (IB + 5) tick();
        instr_ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== AW'(RST_PC + IB)) begin
            n_fail++; $display("FAIL midrst_pre got %b %h want 1 %h", s_valid, s_pc, AW'(RST_PC + IB));
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || mem_addr !== AW'(RST_PC)) begin
            n_fail++;
            $display("FAIL midrst_now got valid %b addr %h want 0 %h", instr_valid, mem_addr,
                     AW'(RST_PC));
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        cyc         = 0;
        instr_ready = 1'b1;
        for (int c = 0; c <= IB + 1; c++) begin
            tick();
            exp_v = (c == IB + 1);
            n_checks++;
            if (s_valid !== exp_v) begin
                n_fail++; $display("FAIL midrst_valid c=%0d got %b want %b", c, s_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (s_pc !== AW'(RST_PC) || s_data !== model_word(AW'(RST_PC))) begin
                    n_fail++;
                    $display("FAIL midrst_word got %h/%h want %h/%h", s_pc, s_data, AW'(RST_PC),
                             model_word(AW'(RST_PC)));
                end
            end
        end
    endtask

    task automatic test_align();
        logic          got;
        logic [AW-1:0] exp_pc;
        apply_reset();
        instr_ready = 1'b1;
        repeat (2) tick();
        jump_valid  = 1'b1;
        jump_target = 16'h0013;
        exp_pc      = model_target(16'h0013);
        tick();
`ifdef PROGRAM_FETCH_ALIGN_CHECK_EN
        n_checks++;
        if (s_align !== 1'b0) begin
            n_fail++; $display("FAIL align_err_t got %b want 0", s_align);
        end
        tick();
        n_checks++;
        if (s_align !== 1'b1 || s_addr !== 16'h0010) begin
            n_fail++; $display("FAIL align_err_t1 got %b %h want 1 0010", s_align, s_addr);
        end
        tick();
        n_checks++;
        if (s_align !== 1'b0) begin
            n_fail++; $display("FAIL align_err_t2 got %b want 0", s_align);
        end
`else
        tick();
        n_checks++;
        if (s_addr !== 16'h0013) begin
            n_fail++; $display("FAIL noalign_addr got %h want 0013", s_addr);
        end
`endif
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = s_hs;
        end
        n_checks++;
        if (!got || s_pc !== exp_pc || s_data !== model_word(exp_pc)) begin
            n_fail++;
            $display("FAIL align_word got %b %h/%h want 1 %h/%h", got, s_pc, s_data, exp_pc,
                     model_word(exp_pc));
        end
    endtask

    task automatic test_random();
        logic [AW-1:0]   exp_pc, jt, last_tgt, prev_pc;
        logic [8*IB-1:0] prev_data;
        logic            jmp, jumped, prev_hold, rdy;
        logic [31:0]     r;
        int              nh;
        apply_reset();
        exp_pc    = AW'(RST_PC);
        jumped    = 1'b0;
        prev_hold = 1'b0;
        last_tgt  = '0;
        prev_pc   = '0;
        prev_data = '0;
        jt        = '0;
        nh        = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 99) < 70);
            jmp = ($urandom_range(0, 49) == 0);
            instr_ready = rdy;
            if (jmp) begin
                r  = $urandom;
                jt = r[AW-1:0];
                if (r[16]) jt[AW-1:4] = '1;
                jump_valid  = 1'b1;
                jump_target = jt;
            end
            tick();
            if (jumped) begin
                n_checks++;
                if (s_addr !== last_tgt) begin
                    n_fail++; $display("FAIL rnd_jump_addr i=%0d got %h want %h", i, s_addr, last_tgt);
                end
            end
            if (prev_hold) begin
                n_checks++;
                if ({s_valid, s_pc, s_data} !== {1'b1, prev_pc, prev_data}) begin
                    n_fail++;
                    $display("FAIL rnd_hold i=%0d got %b %h %h want 1 %h %h", i, s_valid, s_pc,
                             s_data, prev_pc, prev_data);
                end
            end
            if (s_hs) begin
                n_checks++;
                if (s_pc !== exp_pc || s_data !== model_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL rnd_word i=%0d got %h/%h want %h/%h", i, s_pc, s_data, exp_pc,
                             model_word(exp_pc));
                end
                exp_pc = exp_pc + AW'(IB);
                nh++;
            end
            prev_hold = s_valid && !rdy && !jmp;
            prev_pc   = s_pc;
            prev_data = s_data;
            jumped    = jmp;
            if (jmp) begin
                last_tgt = model_target(jt);
                exp_pc   = last_tgt;
            end
        end
        n_checks++;
        if (nh < 100) begin
            n_fail++; $display("FAIL rnd_throughput got %0d words want at least 100", nh);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_wrap();
        test_reset_midword();
        test_align();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
